// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 256x32 data memory.
// Port 0 is the CPU load/store path, port 1 the loader/DMA; lock holds the memory for RMW sequences.
module dmem_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [1:0]          lock,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          ack,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_rEn,
  output logic                mem_wEn,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nx;

  logic ptr, ptr_nx;
  logic own_vld, own_vld_nx;
  logic owner, owner_nx;
  logic win, win_nx;
  logic we_q, we_nx;
  logic lock_q, lock_nx;
  logic err_q, err_q_nx;

  logic [1:0]        gnt_nx, ack_nx;
  logic              err_nx;
  logic [DATA_W-1:0] rdata_nx;
  logic              mem_ren_nx, mem_wen_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx;

  logic [1:0]        eligible;
  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;

  // While a lock owner exists only its request is visible to arbitration.
  always_comb begin
    eligible  = own_vld ? (req & (2'b01 << owner)) : req;
    sel       = eligible[ptr] ? ptr : ~ptr;
    sel_addr  = sel ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    sel_wdata = sel ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    sel_err   = (sel_addr >= ADDR_W'(DEPTH));
  end

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    own_vld_nx   = own_vld;
    owner_nx     = owner;
    win_nx       = win;
    we_nx        = we_q;
    lock_nx      = lock_q;
    err_q_nx     = err_q;
    gnt_nx       = '0;
    ack_nx       = '0;
    err_nx       = 1'b0;
    rdata_nx     = '0;
    mem_ren_nx   = 1'b0;
    mem_wen_nx   = 1'b0;
    mem_addr_nx  = '0;
    mem_wdata_nx = '0;

    case (state)
      IDLE: begin
        if (|eligible) begin
          state_nx     = ACCESS;
          win_nx       = sel;
          we_nx        = we[sel];
          lock_nx      = lock[sel];
          err_q_nx     = sel_err;
          gnt_nx       = sel ? 2'b10 : 2'b01;
          mem_addr_nx  = sel_addr;
          mem_wdata_nx = sel_wdata;
          // mem_rEn is the memory's write strobe, mem_wEn its read strobe.
          mem_ren_nx   = we[sel] & ~sel_err;
          mem_wen_nx   = ~we[sel] & ~sel_err;
        end
      end
      ACCESS: begin
        state_nx = RESP;
        ack_nx   = win ? 2'b10 : 2'b01;
        err_nx   = err_q;
        rdata_nx = (~we_q & ~err_q) ? mem_rdata : '0;
      end
      RESP: begin
        state_nx = IDLE;
        if (lock_q) begin
          own_vld_nx = 1'b1;
          owner_nx   = win;
          ptr_nx     = win;
        end else begin
          own_vld_nx = 1'b0;
          ptr_nx     = ~win;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      own_vld   <= 1'b0;
      owner     <= 1'b0;
      win       <= 1'b0;
      we_q      <= 1'b0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      gnt       <= '0;
      ack       <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_rEn   <= 1'b0;
      mem_wEn   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      own_vld   <= own_vld_nx;
      owner     <= owner_nx;
      win       <= win_nx;
      we_q      <= we_nx;
      lock_q    <= lock_nx;
      err_q     <= err_q_nx;
      gnt       <= gnt_nx;
      ack       <= ack_nx;
      err       <= err_nx;
      rdata     <= rdata_nx;
      mem_rEn   <= mem_ren_nx;
      mem_wEn   <= mem_wen_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
    end
  end

endmodule
